i2c_reg_bank: RTL

Memory-mapped register bank that terminates the I2C bridge's register bus: it consumes the bridge's `addr`/`wdata`/`wr_en`/`rd_en` strobes and returns `rdata`. It holds an ID register, control, write-one-to-clear status, a free-running event counter and a parameterised scratch array. It also raises a level interrupt from masked status bits. It is instantiated beside the I2C top and is the only register target on that bus.

---
 rtl/i2c_reg_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/i2c_reg_bank.sv
// Register bank terminating the I2C bridge register bus: ID, CTRL, W1C STATUS, COUNTER, scratch array, level irq.
// Latency: writes visible 1 cycle after wr_en; rdata valid the cycle after rd_en; irq lags STATUS/CTRL by one cycle.
// Backpressure: none; strobes are accepted every cycle at full rate with no wait states.
module i2c_reg_bank #(
    parameter int          NUM_SCRATCH = 16,
    parameter logic [31:0] ID_VALUE    = 32'h12C0_0001,
    parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] ADDR_ID      = 16'h0000;
    localparam logic [15:0] ADDR_CTRL    = 16'h0001;
    localparam logic [15:0] ADDR_STATUS  = 16'h0002;
    localparam logic [15:0] ADDR_COUNTER = 16'h0003;
    localparam logic [15:0] ADDR_SCR     = 16'h0010;
    localparam logic [16:0] SCR_END      = 17'(16 + NUM_SCRATCH);
    localparam int          IDX_W        = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    logic [31:0]      ctrl;
    logic [2:0]       status;
    logic [31:0]      counter;
    logic [31:0]      scratch [NUM_SCRATCH];

    logic             hit_id;
    logic             hit_ctrl;
    logic             hit_status;
    logic             hit_cnt;
    logic             hit_scr;
    logic             unmapped;
    logic [IDX_W-1:0] scr_idx;
    logic             cnt_clr;
    logic             cnt_wrap;
    logic [2:0]       status_set;
    logic [2:0]       status_w1c;
    logic [31:0]      rd_mux;

    // Address decode and event qualification for this cycle's strobes
    always_comb begin
        hit_id     = (addr == ADDR_ID);
        hit_ctrl   = (addr == ADDR_CTRL);
        hit_status = (addr == ADDR_STATUS);
        hit_cnt    = (addr == ADDR_COUNTER);
        hit_scr    = (addr >= ADDR_SCR) && ({1'b0, addr} < SCR_END);
        unmapped   = !(hit_id || hit_ctrl || hit_status || hit_cnt || hit_scr);
        scr_idx    = IDX_W'(addr - ADDR_SCR);

        // A CTRL write with bit1 zeroes the counter, beating any increment
        cnt_clr    = wr_en && hit_ctrl && wdata[1];
        cnt_wrap   = ctrl[0] && !cnt_clr && (counter == 32'hFFFF_FFFF);

        status_set    = 3'b000;
        status_set[0] = cnt_wrap;
        status_set[1] = (wr_en || rd_en) && unmapped;
        status_set[2] = wr_en && (hit_id || hit_cnt);
        status_w1c    = (wr_en && hit_status) ? wdata[2:0] : 3'b000;
    end

    // Read mux; values are taken before this edge's updates so a
    // same-cycle write returns the old contents
    always_comb begin
        rd_mux = BAD_DATA;
        if (hit_id)
            rd_mux = ID_VALUE;
        else if (hit_ctrl)
            rd_mux = ctrl;
        else if (hit_status)
            rd_mux = {29'd0, status};
        else if (hit_cnt)
            rd_mux = counter;
        else if (hit_scr)
            rd_mux = scratch[scr_idx];
    end

    // CTRL register; the clear bit is a pulse and is never stored
    always_ff @(posedge clk) begin
        if (rst)
            ctrl <= 32'd0;
        else if (wr_en && hit_ctrl)
            ctrl <= wdata & ~32'h0000_0002;
    end

    // STATUS: hardware sets override a simultaneous write-one-to-clear
    always_ff @(posedge clk) begin
        if (rst)
            status <= 3'b000;
        else
            status <= (status & ~status_w1c) | status_set;
    end

    // Free-running event counter with clear priority over increment
    always_ff @(posedge clk) begin
        if (rst)
            counter <= 32'd0;
        else if (cnt_clr)
            counter <= 32'd0;
        else if (ctrl[0])
            counter <= counter + 32'd1;
    end

    // Scratch array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch[i] <= 32'd0;
        end else if (wr_en && hit_scr) begin
            scratch[scr_idx] <= wdata;
        end
    end

    // Read data register; holds until the next read strobe
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= 32'd0;
        else if (rd_en)
            rdata <= rd_mux;
    end

    // Level interrupt from the registered status and mask
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= |(status & ctrl[10:8]);
    end

endmodule
